uart_cmd_responder: RTL and testbench

Register-access responder on the parallel side of `simple_uart`. It consumes received bytes (`rx_value`/`rx_value_ready`) and decodes a 2- or 3-byte command. It performs one 8-bit register read or write on a simple local bus and returns a single reply byte through `tx_value`/`tx_value_write`. It is the device-side end of the host command link that drives the UART.

---
 rtl/uart_cmd_responder_pkg.sv | 36 +++
 rtl/uart_cmd_responder_if.sv | 30 +++
 rtl/uart_cmd_responder.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_cmd_responder_pkg                                       |
// | Description : Shared command/reply codes and FSM encodings for the         |
// |               UART register-access responder and its host-side models.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package uart_cmd_responder_pkg;

    localparam logic [7:0] c_cmd_write = 8'h57;  // 'W'
    localparam logic [7:0] c_cmd_read  = 8'h52;  // 'R'
    localparam logic [7:0] c_rep_ack   = 8'h4B;  // 'K'
    localparam logic [7:0] c_rep_err   = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_ADDR   = 3'd1,
        ST_GET_DATA   = 3'd2,
        ST_DO_WRITE   = 3'd3,
        ST_DO_READ    = 3'd4,
        ST_WAIT_RDATA = 3'd5,
        ST_SEND       = 3'd6,
        ST_HOLD       = 3'd7
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == c_cmd_write) || (b == c_cmd_read);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_cmd_responder_if                                        |
// | Description : Byte stream (UART parallel side) and local register bus     |
// |               seen by the command responder.                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface uart_cmd_responder_if;
    logic [7:0] rx_value;
    logic       rx_value_ready;
    logic [7:0] tx_value;
    logic       tx_value_write;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;

    // The responder answers commands; the master side is the UART + register file.
    modport slave (
        input  rx_value, rx_value_ready, reg_rdata,
        output tx_value, tx_value_write, reg_addr, reg_wdata, reg_write, reg_read
    );

    modport master (
        output rx_value, rx_value_ready, reg_rdata,
        input  tx_value, tx_value_write, reg_addr, reg_wdata, reg_write, reg_read
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_cmd_responder                                           |
// | Description : Decodes 'W addr data' / 'R addr' byte commands, performs one |
// |               register access and returns a single paced reply byte.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int SYSTEM_FREQ    = 50_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic               clock,
    input  logic               srst,
    uart_cmd_responder_if.slave bus
);

    localparam int c_byte_cycles    = (10 * SYSTEM_FREQ) / BAUD_RATE;
    localparam int c_timeout_cycles = TIMEOUT_FRAMES * c_byte_cycles;
    localparam int c_cnt_w          = $clog2(c_timeout_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_gap_load = c_cnt_w'(c_byte_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(c_timeout_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state, w_state_nxt;
    op_t                r_op, w_op_nxt;
    logic [c_cnt_w-1:0] r_gap, w_gap_nxt;
    logic [c_cnt_w-1:0] r_tmo, w_tmo_nxt;
    logic [7:0]         r_tx_value, w_tx_value_nxt;
    logic               r_tx_write, w_tx_write_nxt;
    logic [7:0]         r_addr, w_addr_nxt;
    logic [7:0]         r_wdata, w_wdata_nxt;
    logic               r_reg_write, w_reg_write_nxt;
    logic               r_reg_read, w_reg_read_nxt;

    always_ff @(posedge clock) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_WRITE;
            r_gap       <= '0;
            r_tmo       <= '0;
            r_tx_value  <= 8'h00;
            r_tx_write  <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_reg_write <= 1'b0;
            r_reg_read  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_gap       <= w_gap_nxt;
            r_tmo       <= w_tmo_nxt;
            r_tx_value  <= w_tx_value_nxt;
            r_tx_write  <= w_tx_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_reg_read  <= w_reg_read_nxt;
        end
    end

    // Strobes are raised on the transition into their state so every output
    // comes straight from a flop and is valid in the state's own cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_gap_nxt       = r_gap;
        w_tmo_nxt       = r_tmo;
        w_tx_value_nxt  = r_tx_value;
        w_tx_write_nxt  = 1'b0;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_reg_write_nxt = 1'b0;
        w_reg_read_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_value_ready) begin
                    if (is_opcode(bus.rx_value)) begin
                        w_state_nxt = ST_GET_ADDR;
                        w_op_nxt    = (bus.rx_value == c_cmd_write) ? OP_WRITE : OP_READ;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_state_nxt    = ST_SEND;
                        w_tx_value_nxt = c_rep_err;
                        w_tx_write_nxt = 1'b1;
                    end
                end
            end
            ST_GET_ADDR, ST_GET_DATA: begin
                if (bus.rx_value_ready) begin
                    w_tmo_nxt = '0;
                    if (r_state == ST_GET_ADDR) begin
                        w_addr_nxt = bus.rx_value;
                        if (r_op == OP_WRITE) begin
                            w_state_nxt = ST_GET_DATA;
                        end else begin
                            w_state_nxt    = ST_DO_READ;
                            w_reg_read_nxt = 1'b1;
                        end
                    end else begin
                        w_wdata_nxt     = bus.rx_value;
                        w_state_nxt     = ST_DO_WRITE;
                        w_reg_write_nxt = 1'b1;
                    end
                end else if (r_tmo == c_tmo_last) begin
                    // Last allowed idle cycle spent: the reply follows immediately.
                    w_state_nxt    = ST_SEND;
                    w_tx_value_nxt = c_rep_err;
                    w_tx_write_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + c_cnt_one;
                end
            end
            ST_DO_WRITE: begin
                w_state_nxt    = ST_SEND;
                w_tx_value_nxt = c_rep_ack;
                w_tx_write_nxt = 1'b1;
            end
            ST_DO_READ: begin
                w_state_nxt = ST_WAIT_RDATA;
            end
            ST_WAIT_RDATA: begin
                w_state_nxt    = ST_SEND;
                w_tx_value_nxt = bus.reg_rdata;
                w_tx_write_nxt = 1'b1;
            end
            ST_SEND: begin
                w_state_nxt = ST_HOLD;
                w_gap_nxt   = c_gap_load;
            end
            ST_HOLD: begin
                if (r_gap == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_value       = r_tx_value;
    assign bus.tx_value_write = r_tx_write;
    assign bus.reg_addr       = r_addr;
    assign bus.reg_wdata      = r_wdata;
    assign bus.reg_write      = r_reg_write;
    assign bus.reg_read       = r_reg_read;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_cmd_responder                                        |
// | Description : Directed + randomized bench with a cycle-scheduled reference |
// |               model and a per-cycle output comparator.                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_uart_cmd_responder;
    import uart_cmd_responder_pkg::*;

    localparam int SYS_F   = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int TMO_FR  = 4;
    localparam int BYTE_C  = (10 * SYS_F) / BAUD;
    localparam int TMO_C   = TMO_FR * BYTE_C;

    logic clock = 1'b0;
    logic srst  = 1'b1;

    uart_cmd_responder_if bus();

    uart_cmd_responder #(
        .SYSTEM_FREQ    (SYS_F),
        .BAUD_RATE      (BAUD),
        .TIMEOUT_FRAMES (TMO_FR)
    ) dut (
        .clock (clock),
        .srst  (srst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: schedules expected events at absolute cycle numbers.
    logic [7:0] mem [256];
    logic [7:0] model_mem [256];
    logic [7:0] cmd [$];
    int         last_c   = 0;
    int         ready_at = 0;
    logic [7:0] tx_at [int];
    logic [7:0] addr_at [int];
    logic [7:0] wd_at [int];
    bit         wr_at [int];
    bit         rd_at [int];
    bit         rst_at [int];

    task automatic reply(input int c, input logic [7:0] v);
        tx_at[c] = v;
        ready_at = c + BYTE_C + 1;
    endtask

    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clock);
            if (srst === 1'b1) begin
                cmd.delete();
                for (int k = cyc + 1; k <= cyc + 3; k++) begin
                    if (tx_at.exists(k))   tx_at.delete(k);
                    if (addr_at.exists(k)) addr_at.delete(k);
                    if (wd_at.exists(k))   wd_at.delete(k);
                    if (wr_at.exists(k))   wr_at.delete(k);
                    if (rd_at.exists(k))   rd_at.delete(k);
                end
                rst_at[cyc + 1] = 1'b1;
                ready_at = cyc + 1;
            end else begin
                b = bus.rx_value;
                if (cmd.size() > 0) begin
                    if (bus.rx_value_ready === 1'b1) begin
                        cmd.push_back(b);
                        last_c = cyc;
                        if (cmd.size() == 2) begin
                            addr_at[cyc + 1] = b;
                            if (cmd[0] == c_cmd_read) begin
                                rd_at[cyc + 1] = 1'b1;
                                reply(cyc + 3, model_mem[b]);
                                cmd.delete();
                            end
                        end else begin
                            wd_at[cyc + 1] = b;
                            wr_at[cyc + 1] = 1'b1;
                            model_mem[cmd[1]] = b;
                            reply(cyc + 2, c_rep_ack);
                            cmd.delete();
                        end
                    end else if (cyc == last_c + TMO_C) begin
                        reply(cyc + 1, c_rep_err);
                        cmd.delete();
                    end
                end else if (bus.rx_value_ready === 1'b1 && cyc >= ready_at) begin
                    if (b == c_cmd_write || b == c_cmd_read) begin
                        cmd.push_back(b);
                        last_c = cyc;
                    end else begin
                        reply(cyc + 1, c_rep_err);
                    end
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparator against the scheduled expectations.
    initial begin
        logic [7:0] e_tx, e_addr, e_wd;
        int last_tx;
        e_tx = 8'h00; e_addr = 8'h00; e_wd = 8'h00; last_tx = -1;
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                if (rst_at.exists(cyc)) begin
                    e_tx = 8'h00; e_addr = 8'h00; e_wd = 8'h00; last_tx = -1;
                end
                if (tx_at.exists(cyc))   e_tx   = tx_at[cyc];
                if (addr_at.exists(cyc)) e_addr = addr_at[cyc];
                if (wd_at.exists(cyc))   e_wd   = wd_at[cyc];
                chk("tx_value_write", bus.tx_value_write, tx_at.exists(cyc));
                chk("tx_value", bus.tx_value, e_tx);
                chk("reg_addr", bus.reg_addr, e_addr);
                chk("reg_wdata", bus.reg_wdata, e_wd);
                chk("reg_write", bus.reg_write, wr_at.exists(cyc));
                chk("reg_read", bus.reg_read, rd_at.exists(cyc));
                if (bus.tx_value_write === 1'b1) begin
                    if (last_tx >= 0) chk("reply_spacing_ok", (cyc - last_tx) >= BYTE_C + 1, 1);
                    last_tx = cyc;
                end
            end
        end
    end

    // Register file: read data is valid only in the cycle after reg_read.
    initial begin
        logic       rd;
        logic [7:0] ra;
        bus.reg_rdata = 8'h00;
        forever begin
            @(negedge clock);
            rd = bus.reg_read;
            ra = bus.reg_addr;
            if (bus.reg_write === 1'b1) mem[bus.reg_addr] = bus.reg_wdata;
            @(posedge clock);
            #1;
            bus.reg_rdata = (rd === 1'b1) ? mem[ra] : 8'($urandom);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_value       = b;
        bus.rx_value_ready = 1'b1;
        tick(1);
        bus.rx_value_ready = 1'b0;
        bus.rx_value       = 8'($urandom);
    endtask

    initial begin
        int n, m, k;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            model_mem[i] = mem[i];
        end
        mem[8'h34] = 8'h5C;
        model_mem[8'h34] = 8'h5C;
        bus.rx_value = 8'h00;
        bus.rx_value_ready = 1'b0;
        srst = 1'b1;
        tick(3);
        srst = 1'b0;
        chk("rst_tx_value", bus.tx_value, 8'h00);
        chk("rst_tx_write", bus.tx_value_write, 1'b0);
        chk("rst_reg_addr", bus.reg_addr, 8'h00);
        chk("rst_reg_wdata", bus.reg_wdata, 8'h00);
        tick(2);

        // Write
        send(8'h57); send(8'h12);
        n = cyc; send(8'hA5);
        chk("wr_strobe_n1", bus.reg_write, 1'b1);
        chk("wr_addr_n1", bus.reg_addr, 8'h12);
        chk("wr_data_n1", bus.reg_wdata, 8'hA5);
        tick(1);
        chk("wr_reply_n2", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h4B});
        chk("wr_reply_cycle", cyc, n + 2);
        tick(110);

        // Read
        send(8'h52);
        send(8'h34);
        chk("rd_strobe_n1", bus.reg_read, 1'b1);
        tick(1);
        chk("rd_strobe_once", bus.reg_read, 1'b0);
        tick(1);
        chk("rd_reply_n3", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h5C});
        tick(110);

        // Bad opcode
        send(8'h00);
        chk("bad_reply_n1", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h45});
        chk("bad_no_strobe", {bus.reg_write, bus.reg_read}, 2'b00);
        tick(110);

        // Timeout after partial write, then a normal write
        send(8'h57); send(8'h12);
        tick(399);
        chk("tmo_not_yet", bus.tx_value_write, 1'b0);
        tick(1);
        chk("tmo_reply", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h45});
        tick(110);
        send(8'h57); send(8'h40); send(8'h77);
        chk("post_tmo_write", {bus.reg_write, bus.reg_addr, bus.reg_wdata}, {1'b1, 8'h40, 8'h77});
        tick(1);
        chk("post_tmo_ack", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h4B});
        tick(110);

        // Back-to-back: command during HOLD dropped, later one served
        n = cyc; send(8'hFF);
        tick(20);
        send(8'h52); send(8'h34);
        chk("hold_drop_no_read", bus.reg_read, 1'b0);
        tick(2);
        chk("hold_drop_no_reply", bus.tx_value_write, 1'b0);
        tick(85);
        m = cyc; send(8'h52); send(8'h34);
        tick(2);
        chk("b2b_served", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h5C});
        chk("b2b_spacing", (m + 4) - (n + 1) >= 101, 1);
        tick(110);

        // Reset between addr and data
        send(8'h57); send(8'h12);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        chk("mid_rst_outputs", {bus.tx_value_write, bus.reg_write, bus.reg_addr, bus.reg_wdata},
            {1'b0, 1'b0, 8'h00, 8'h00});
        tick(5);
        send(8'h57); send(8'h12); send(8'hA5);
        chk("fresh_write", {bus.reg_write, bus.reg_addr, bus.reg_wdata}, {1'b1, 8'h12, 8'hA5});
        tick(1);
        chk("fresh_ack", {bus.tx_value_write, bus.tx_value}, {1'b1, 8'h4B});
        tick(110);

        // Randomized traffic; the comparator tracks everything against the model.
        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                send(c_cmd_write); tick($urandom_range(0, 20));
                send(8'($urandom_range(0, 15))); tick($urandom_range(0, 20));
                send(8'($urandom));
            end else if (k <= 6) begin
                send(c_cmd_read); tick($urandom_range(0, 20));
                send(8'($urandom_range(0, 15)));
            end else if (k == 7) begin
                send(8'($urandom));
            end else if (k == 8) begin
                send(c_cmd_write);
                if ($urandom_range(0, 1) == 1) send(8'($urandom));
                tick(TMO_C + $urandom_range(0, 3));
            end else begin
                send(c_cmd_write); tick($urandom_range(0, 5));
                srst = 1'b1;
                tick($urandom_range(1, 2));
                srst = 1'b0;
            end
            tick($urandom_range(0, 140));
        end
        tick(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
